// File: rtl/sr_pulse_gen.sv
// rtl/sr_pulse_gen.sv - debounced set/clear pulse generator for a downstream SR flip-flop
module sr_pulse_gen #(
  parameter int DB_CYCLES  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] R_PULSE  = 3'd2;
  localparam logic [2:0] CONFLICT = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  // Channel 0 is set, channel 1 is clear.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [CW-1:0] cnt [2];
  logic [1:0]    rise;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] gap_cnt;

  assign raw  = {clr_in, set_in};
  assign rise = deb & ~deb_d;

  // Two-flop synchronizers, one per raw input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a new level is accepted only after it has been stable DB_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb   <= 2'b00;
      deb_d <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next-state decode; rises seen outside IDLE are simply ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise[0] && rise[1])  state_nxt = CONFLICT;
        else if (rise[0])        state_nxt = S_PULSE;
        else if (rise[1])        state_nxt = R_PULSE;
      end
      S_PULSE, R_PULSE, CONFLICT: state_nxt = GAP;
      GAP: begin
        if (gap_cnt == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and lockout down-counter, loaded on entry to GAP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GAP && state != GAP) begin
        gap_cnt <= 8'(GAP_CYCLES - 1);
      end else if (state == GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

  // Outputs registered alongside the state so they decode the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= (state_nxt == S_PULSE);
      r        <= (state_nxt == R_PULSE);
      busy     <= (state_nxt != IDLE);
      conflict <= (state_nxt == CONFLICT);
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb/tb_sr_pulse_gen.sv - scoreboard bench for sr_pulse_gen
module tb_sr_pulse_gen;

  localparam int K_S = 1;
  localparam int K_R = 2;
  localparam int K_C = 3;

  logic clk = 1'b0;
  logic rst;
  logic set_in;
  logic clr_in;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t evq[$];
  int  fallq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  logic q = 1'b0;
  logic busy_prev = 1'b0;

  sr_pulse_gen #(.DB_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .set_in(set_in),
    .clr_in(clr_in),
    .s(s),
    .r(r),
    .busy(busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge N, cyc reads N.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected pulses and busy falls whenever the DUT shows them.
  always @(negedge clk) begin
    int kind;
    ev_t e;
    kind = 0;
    if (s === 1'b1 && r === 1'b1) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL s_r_overlap cyc=%0d s=%b r=%b required not both high", cyc, s, r);
    end
    if (s === 1'b1) kind = K_S;
    else if (r === 1'b1) kind = K_R;
    else if (conflict === 1'b1) kind = K_C;
    if (kind != 0) begin
      checks = checks + 1;
      if (evq.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_pulse kind=%0d cyc=%0d required none", kind, cyc);
      end else begin
        e = evq.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
          failures = failures + 1;
          $display("FAIL pulse kind=%0d cyc=%0d required kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
        end
      end
    end
    if (busy_prev && busy !== 1'b1) begin
      checks = checks + 1;
      if (fallq.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_busy_fall cyc=%0d required none", cyc);
      end else begin
        int f;
        f = fallq.pop_front();
        if (f != cyc) begin
          failures = failures + 1;
          $display("FAIL busy_fall cyc=%0d required cyc=%0d", cyc, f);
        end
      end
    end
    busy_prev = (busy === 1'b1);
    if (s === 1'b1) q = 1'b1;
    else if (r === 1'b1) q = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse expected in the cycle after edge now+7; busy covers pulse plus two gap cycles.
  task automatic expect_op(input int kind, input int pulse_cyc, input int fall_cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = pulse_cyc;
    evq.push_back(e);
    fallq.push_back(fall_cyc);
  endtask

  task automatic drain(input string name);
    checks = checks + 1;
    if (evq.size() != 0 || fallq.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s missing_events pulses=%0d busy_falls=%0d required 0 and 0", name, evq.size(), fallq.size());
    end
    evq.delete();
    fallq.delete();
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    set_in = 1'b1;
    clr_in = 1'b0;

    // Reset held with set_in high, then released: held level counts as a fresh rise.
    step(2);
    check_bit("reset_s", s, 1'b0);
    check_bit("reset_r", r, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_conflict", conflict, 1'b0);
    rst = 1'b1;
    n = cyc;
    expect_op(K_S, n + 7, n + 10);
    step(12);
    set_in = 1'b0;
    step(20);
    drain("reset_release");

    // Set then clear, tracking a downstream SR flip-flop.
    n = cyc;
    set_in = 1'b1;
    expect_op(K_S, n + 7, n + 10);
    step(10);
    set_in = 1'b0;
    step(15);
    drain("set");
    check_bit("sr_q_after_set", q, 1'b1);
    n = cyc;
    clr_in = 1'b1;
    expect_op(K_R, n + 7, n + 10);
    step(10);
    clr_in = 1'b0;
    step(15);
    drain("clear");
    check_bit("sr_q_after_clear", q, 1'b0);

    // Short glitch on set_in must be filtered.
    set_in = 1'b1;
    step(2);
    set_in = 1'b0;
    step(20);
    drain("glitch");
    check_bit("glitch_busy", busy, 1'b0);

    // Simultaneous rises give a conflict flag only.
    n = cyc;
    set_in = 1'b1;
    clr_in = 1'b1;
    expect_op(K_C, n + 7, n + 10);
    step(10);
    set_in = 1'b0;
    clr_in = 1'b0;
    step(15);
    drain("simultaneous");

    // Clear rise lands one cycle after the s pulse, inside the lockout: dropped.
    n = cyc;
    set_in = 1'b1;
    expect_op(K_S, n + 7, n + 10);
    step(2);
    clr_in = 1'b1;
    step(10);
    set_in = 1'b0;
    clr_in = 1'b0;
    step(15);
    drain("lockout");
    check_bit("lockout_q", q, 1'b1);
    n = cyc;
    clr_in = 1'b1;
    expect_op(K_R, n + 7, n + 10);
    step(10);
    clr_in = 1'b0;
    step(15);
    drain("repress_clear");
    check_bit("repress_q", q, 1'b0);

    // Reset sampled on the edge ending the s pulse aborts the operation.
    n = cyc;
    set_in = 1'b1;
    expect_op(K_S, n + 7, n + 8);
    step(7);
    rst = 1'b0;
    set_in = 1'b0;
    step(1);
    check_bit("midop_s", s, 1'b0);
    check_bit("midop_busy", busy, 1'b0);
    rst = 1'b1;
    step(20);
    drain("midop_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_pulse_gen.md
SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles needed to accept a new input level; legal range 2..255.
REQ-002 Parameter GAP_CYCLES, default 2: lockout cycles after each emitted pulse or conflict; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 set_in  input  1  raw asynchronous set request (button/level).
REQ-006 clr_in  input  1  raw asynchronous clear request (button/level).
REQ-007 s  output  1  one-cycle set pulse to the downstream SR flip-flop S input.
REQ-008 r  output  1  one-cycle reset pulse to the downstream SR flip-flop R input.
REQ-009 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-010 conflict  output  1  one-cycle flag when set and clear edges are accepted on the same cycle.

Function
REQ-011 Each raw input SHALL pass through its own 2-flop synchronizer (sync1 -> sync2) before any other logic.
REQ-012 Per channel, a debounced level deb and a counter cnt (width ceil(log2(DB_CYCLES))) SHALL be kept: sync2 == deb -> cnt <= 0; sync2 != deb and cnt < DB_CYCLES-1 -> cnt++; sync2 != deb and cnt == DB_CYCLES-1 -> deb <= sync2, cnt <= 0.
REQ-013 A rise event SHALL be deb & ~deb_d, where deb_d is deb delayed by one cycle; falling debounced edges SHALL generate no event.
REQ-014 FSM states: IDLE, S_PULSE, R_PULSE, CONFLICT, GAP; all outputs SHALL be registered and decoded from state only.
REQ-015 IDLE: set_rise & clr_rise -> CONFLICT; set_rise only -> S_PULSE; clr_rise only -> R_PULSE; otherwise stay.
REQ-016 S_PULSE, R_PULSE, CONFLICT: each lasts exactly one cycle, then -> GAP.
REQ-017 s = 1 only in S_PULSE; r = 1 only in R_PULSE; conflict = 1 only in CONFLICT; s and r SHALL never be high together.
REQ-018 GAP: lasts exactly GAP_CYCLES cycles (down-counter loaded on entry), then -> IDLE.
REQ-019 Rise events arriving while not in IDLE SHALL be dropped, not queued; debounce logic keeps tracking levels.
REQ-020 Latency: with set_in held high and first sampled high at edge 1, s SHALL be high in the cycle following edge DB_CYCLES+3 (edge 7 for default); same for clr_in/r.
REQ-021 Glitch rejection: any input pulse shorter than DB_CYCLES consecutive synchronized cycles SHALL produce no event.
REQ-022 Back-to-back: minimum spacing between consecutive s/r pulses SHALL be GAP_CYCLES+1 cycles.

Reset
REQ-023 On any clk edge with rst = 0: sync flops, deb, deb_d, cnt, gap counter cleared; state <= IDLE; s, r, busy, conflict read 0 in the following cycle.
REQ-024 Reset asserted mid-pulse or mid-GAP SHALL abort the operation with no residual pulse after release.
REQ-025 An input held high across reset release SHALL be treated as a fresh rise and produce one pulse after REQ-020 latency.

Verification
REQ-026 Reset: rst = 0 for 2 edges with set_in = 1 -> s = r = busy = conflict = 0; release, hold set_in -> single s pulse at edge 7 after release.
REQ-027 Set then clear: set_in 0->1 held 10 cycles -> exactly one s pulse at edge 7, busy high 1+2 cycles; later clr_in 0->1 held -> exactly one r pulse; downstream SR FF q goes 1 then 0.
REQ-028 Glitch: set_in high for 2 cycles (DB_CYCLES = 4) -> no s pulse, busy stays 0.
REQ-029 Simultaneous: set_in and clr_in rise same cycle, held -> conflict = 1 one cycle, s = r = 0 throughout.
REQ-030 Lockout: clr_in rise debounced 1 cycle after s pulse -> r never asserted; clr_in released and re-pressed after GAP -> one r pulse.
REQ-031 Mid-op reset: rst = 0 on the S_PULSE cycle -> s low next cycle, no further pulses until a new rise.
